bus_cycle_fsm: RTL and testbench
================================

Name: bus_cycle_fsm

Overview:
- Parametrised bus-cycle controller; successor to the single-beat read/wait-state/done sequencer.
- Adds write cycles, multi-beat bursts of programmable length, a beat index output and a wait-state timeout with error reporting.
- Sits between a command source (go/wr/len) and a slave bus using a ws wait-state handshake.
- All outputs are registered and decoded from next-state.

Parameters:
- LEN_W, 4, width of burst length field; bursts of 1..2^LEN_W beats.
- TIMEOUT, 8, consecutive ws-high DLY samples that abort the cycle (must be >= 1).
- TO_W, $clog2(TIMEOUT+1), width of the wait-state counter (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- go  input  1  start request, sampled only in IDLE.
- wr  input  1  cycle type, captured with go: 1 = write, 0 = read.
- len  input  LEN_W  beats minus one, captured with go.
- ws  input  1  slave wait-state, sampled in DLY.
- rd  output  1  read strobe.
- wr_en  output  1  write strobe.
- ds  output  1  done strobe, 1-cycle pulse on successful completion.
- err  output  1  timeout error, 1-cycle pulse.
- busy  output  1  high whenever next-state != IDLE.
- beat  output  LEN_W  index of the current beat, 0-based.

Behaviour:
- One clock domain; one-hot states IDLE, XFER, DLY, DONE, ERR.
- Reset: state=IDLE; rd=wr_en=ds=err=busy=0; beat=0; wait counter=0; captured wr/len=0.
- IDLE: go=1 -> XFER, capture wr and len, beat=0, wait counter=0. go=0 -> IDLE.
- XFER: always -> DLY.
- DLY, ws=0, beat==len_q: -> DONE.
- DLY, ws=0, beat!=len_q: -> XFER, beat+1, wait counter cleared.
- DLY, ws=1, wait counter==TIMEOUT-1: -> ERR.
- DLY, ws=1, otherwise: -> XFER (beat re-issued), wait counter+1.
- DONE -> IDLE. ERR -> IDLE.
- Illegal or unreachable state -> IDLE on the next edge.
- Outputs are registered every edge from next-state:
  - rd = (next in {XFER,DLY}) & !wr_q
  - wr_en = (next in {XFER,DLY}) & wr_q
  - ds = (next==DONE)
  - err = (next==ERR)
  - busy = (next!=IDLE)
- At the go edge, the strobe polarity uses the wr input directly, since wr_q is not yet valid.
- Latency, single beat with no wait: go sampled at edge 0 -> rd high after edges 0 and 1 -> ds high after edge 2, rd low -> idle after edge 3.
- Minimum 4 cycles per single-beat transaction; each extra beat adds 2 cycles; each wait retry adds 2 cycles.
- go while not IDLE is ignored; no queuing. go is re-sampled in the cycle after DONE/ERR returns to IDLE.
- len/wr changes mid-cycle have no effect on the running transaction.
- beat wraps never: max value equals len_q ≤ 2^LEN_W-1. The wait counter saturates via the ERR exit.
- rst asserted mid-transaction: at the next edge all outputs go to 0 and state to IDLE. No ds or err is generated.
- rd and wr_en are never high together. ds and err are never high together.

Optional Feature:
- Macro BUS_CYCLE_TIMEOUT_EN.
- Defined: timeout logic exactly as described above.
- Undefined:
  - No wait counter.
  - DLY with ws=1 always -> XFER; retries are unbounded.
  - ERR state is unreachable; err is tied to 0.
  - TIMEOUT is unused.

Test Plan:
- Reset: hold rst=1 for 3 cycles with go=1 -> all outputs 0, state stays IDLE. Release -> rd=1 one cycle later.
- Read, len=0, ws=0: go=1,wr=0 -> rd high 2 cycles, ds high 1 cycle at cycle 3, busy high cycles 1-3, wr_en never high.
- Write burst, len=3, ws=0: -> wr_en high 8 cycles, beat steps 0,1,2,3, single ds pulse, then idle.
- Wait states, len=0, ws=1 for first 2 DLY samples: -> 3 XFER/DLY pairs (rd high 6 cycles), then ds=1, err=0.
- Timeout, TIMEOUT=8, ws held 1: -> err pulses after the 8th ws-high DLY sample, ds=0, busy drops next cycle. With macro undefined -> rd stays asserted, no err after 100 cycles.
- Reset mid-burst, len=3, rst at beat=2: -> next cycle rd=busy=0, beat=0, no ds/err. A new go then starts at beat 0.

Source files
------------

// File: rtl/bus_cycle_fsm.sv
// Bus-cycle controller: read/write bursts of 1..2^LEN_W beats against a ws wait-state slave.
// Latency: go edge -> strobe next cycle; single beat, no wait = 4 cycles; +2 per beat or retry.
// Backpressure: ws=1 in DLY re-issues the beat; go is ignored while not IDLE (no queuing).
// Optional: define BUS_CYCLE_TIMEOUT_EN to abort a beat with an err pulse after TIMEOUT
// consecutive ws-high samples; without it retries are unbounded and err is tied low.
module bus_cycle_fsm #(
  parameter  int LEN_W   = 4,
  parameter  int TIMEOUT = 8,
  localparam int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             wr,
  input  logic [LEN_W-1:0] len,
  input  logic             ws,
  output logic             rd,
  output logic             wr_en,
  output logic             ds,
  output logic             err,
  output logic             busy,
  output logic [LEN_W-1:0] beat
);

  // One-hot encoding; anything else falls back to IDLE.
  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    XFER = 5'b00010,
    DLY  = 5'b00100,
    DONE = 5'b01000,
    ERR  = 5'b10000
  } state_t;

  // Reject a zero timeout at elaboration; a zero-length budget has no meaning.
  if (TIMEOUT < 1 || TO_W < 1) begin : g_bad_timeout
    $error("bus_cycle_fsm: TIMEOUT must be >= 1");
  end

  state_t           state;
  state_t           state_nxt;
  logic             wr_q;
  logic             wr_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_nxt;
  logic [LEN_W-1:0] beat_nxt;
  logic             strobe_nxt;

`ifdef BUS_CYCLE_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0]  wcnt_q;
  logic [TO_W-1:0]  wcnt_nxt;
`endif

  // Next-state and next-datapath decode; everything registered below comes from here.
  always_comb begin
    state_nxt = IDLE;
    wr_nxt    = wr_q;
    len_nxt   = len_q;
    beat_nxt  = beat;
`ifdef BUS_CYCLE_TIMEOUT_EN
    wcnt_nxt  = wcnt_q;
`endif
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = XFER;
          wr_nxt    = wr;
          len_nxt   = len;
          beat_nxt  = '0;
`ifdef BUS_CYCLE_TIMEOUT_EN
          wcnt_nxt  = '0;
`endif
        end else begin
          state_nxt = IDLE;
        end
      end
      XFER: begin
        state_nxt = DLY;
      end
      DLY: begin
        if (!ws) begin
          if (beat == len_q) begin
            state_nxt = DONE;
          end else begin
            state_nxt = XFER;
            beat_nxt  = beat + 1'b1;
`ifdef BUS_CYCLE_TIMEOUT_EN
            wcnt_nxt  = '0;
`endif
          end
        end else begin
`ifdef BUS_CYCLE_TIMEOUT_EN
          // Counter saturates by leaving through ERR rather than wrapping.
          if (wcnt_q == TO_LAST) begin
            state_nxt = ERR;
          end else begin
            state_nxt = XFER;
            wcnt_nxt  = wcnt_q + 1'b1;
          end
`else
          state_nxt = XFER;
`endif
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      ERR: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // At the go edge wr_nxt is the live wr input, so polarity is right immediately.
    strobe_nxt = (state_nxt == XFER) || (state_nxt == DLY);
  end

  // State, captured command and all outputs registered from next-state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_q  <= 1'b0;
      len_q <= '0;
      beat  <= '0;
      rd    <= 1'b0;
      wr_en <= 1'b0;
      ds    <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_q  <= wr_nxt;
      len_q <= len_nxt;
      beat  <= beat_nxt;
      rd    <= strobe_nxt & ~wr_nxt;
      wr_en <= strobe_nxt & wr_nxt;
      ds    <= (state_nxt == DONE);
`ifdef BUS_CYCLE_TIMEOUT_EN
      err   <= (state_nxt == ERR);
`else
      err   <= 1'b0;
`endif
      busy  <= (state_nxt != IDLE);
    end
  end

`ifdef BUS_CYCLE_TIMEOUT_EN
  // Consecutive ws-high counter for the beat currently being retried.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_bus_cycle_fsm.sv
// Scoreboard bench for bus_cycle_fsm: expected per-cycle output records are queued by
// the stimulus; the monitor pops one whenever the DUT shows any activity.
module tb_bus_cycle_fsm;

  localparam int LEN_W   = 4;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic             rd;
    logic             wr_en;
    logic             ds;
    logic             err;
    logic             busy;
    logic [LEN_W-1:0] beat;
  } obs_t;

  logic             clk;
  logic             rst;
  logic             go;
  logic             wr;
  logic [LEN_W-1:0] len;
  logic             ws;
  logic             rd;
  logic             wr_en;
  logic             ds;
  logic             err;
  logic             busy;
  logic [LEN_W-1:0] beat;

  obs_t exp_q[$];
  int   vectors;
  int   miscompares;

  bus_cycle_fsm #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .go    (go),
    .wr    (wr),
    .len   (len),
    .ws    (ws),
    .rd    (rd),
    .wr_en (wr_en),
    .ds    (ds),
    .err   (err),
    .busy  (busy),
    .beat  (beat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic r, input logic w, input logic d, input logic e,
                      input logic b, input logic [LEN_W-1:0] bt);
    obs_t o;
    o.rd = r; o.wr_en = w; o.ds = d; o.err = e; o.busy = b; o.beat = bt;
    exp_q.push_back(o);
  endtask

  task automatic push_n(input int n, input logic r, input logic w, input logic [LEN_W-1:0] bt);
    for (int i = 0; i < n; i++) push(r, w, 1'b0, 1'b0, 1'b1, bt);
  endtask

  // Issue one go pulse; returns 1 ns after the edge that sampled it, with wr/len scrambled.
  task automatic start(input logic w, input logic [LEN_W-1:0] l);
    go = 1'b1; wr = w; len = l;
    tick(1);
    go = 1'b0; wr = ~w; len = ~l;
  endtask

  task automatic chk_idle(input string name);
    vectors++;
    if ({rd, wr_en, ds, err, busy} !== 5'b0 || beat !== '0) begin
      miscompares++;
      $display("FAIL %s: got rd=%b wr_en=%b ds=%b err=%b busy=%b beat=%0d, expected all zero",
               name, rd, wr_en, ds, err, busy, beat);
    end
  endtask

  // Monitor: any active output cycle consumes one expected record.
  always @(negedge clk) begin
    obs_t got;
    obs_t e;
    got = '{rd: rd, wr_en: wr_en, ds: ds, err: err, busy: busy, beat: beat};
    if ((rd | wr_en | ds | err | busy) === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_cycle at %0t: got rd=%b wr_en=%b ds=%b err=%b busy=%b beat=%0d, expected idle",
                 $time, rd, wr_en, ds, err, busy, beat);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL cycle_compare at %0t: got rd=%b wr_en=%b ds=%b err=%b busy=%b beat=%0d, expected rd=%b wr_en=%b ds=%b err=%b busy=%b beat=%0d",
                   $time, rd, wr_en, ds, err, busy, beat,
                   e.rd, e.wr_en, e.ds, e.err, e.busy, e.beat);
        end
      end
    end
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; go = 1'b1; wr = 1'b0; len = '0; ws = 1'b0;

    // Reset held with go high, then a single-beat read launched by the release.
    push_n(2, 1'b1, 1'b0, 4'd0);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_idle("reset_hold");
    end
    rst = 1'b0;
    tick(1);
    go = 1'b0; wr = 1'b1; len = 4'hf;
    tick(4);
    chk_idle("read_single_end");

    // Write burst len=3, with a go pulse mid-burst that must be ignored.
    for (int b = 0; b < 4; b++) push_n(2, 1'b0, 1'b1, 4'(b));
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
    start(1'b1, 4'd3);
    tick(3);
    go = 1'b1;
    tick(1);
    go = 1'b0;
    tick(6);

    // Two wait-state retries on a single-beat read.
    ws = 1'b1;
    push_n(6, 1'b1, 1'b0, 4'd0);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    start(1'b0, 4'd0);
    tick(4);
    ws = 1'b0;
    tick(5);

    // ws held high: abort after TIMEOUT samples, or unbounded retries without the feature.
    ws = 1'b1;
`ifdef BUS_CYCLE_TIMEOUT_EN
    push_n(2 * TIMEOUT, 1'b1, 1'b0, 4'd0);
    push(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    start(1'b0, 4'd0);
    tick(2 * TIMEOUT + 2);
    ws = 1'b0;
`else
    push_n(102, 1'b1, 1'b0, 4'd0);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    start(1'b0, 4'd0);
    tick(100);
    ws = 1'b0;
    tick(4);
`endif
    chk_idle("after_long_wait");

    // Reset while beat 2 of a 4-beat read is in flight, then a fresh 2-beat read.
    push_n(2, 1'b1, 1'b0, 4'd0);
    push_n(2, 1'b1, 1'b0, 4'd1);
    push_n(1, 1'b1, 1'b0, 4'd2);
    start(1'b0, 4'd3);
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk_idle("mid_burst_reset");
    push_n(2, 1'b1, 1'b0, 4'd0);
    push_n(2, 1'b1, 1'b0, 4'd1);
    push(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1);
    start(1'b0, 4'd1);
    tick(6);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d records left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
